// File: rtl/branch_resolve_pred.sv
// rtl/branch_resolve_pred.sv - flag register, branch-condition resolve, 2-bit BHT predictor and branch statistics
module branch_resolve_pred #(
    parameter int PC_W      = 16,
    parameter int BHT_DEPTH = 16,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flag_we,
    input  logic [2:0]       flag_in,
    output logic [2:0]       flag_q,
    input  logic [PC_W-1:0]  id_pc,
    output logic             id_pred_taken,
    input  logic             rs_valid,
    input  logic             rs_b,
    input  logic [2:0]       rs_cond,
    input  logic [PC_W-1:0]  rs_pc,
    input  logic             rs_pred_taken,
    output logic             b_s,
    output logic             mispredict,
    output logic             flush,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mispred_count
);
    localparam int IDX_W = $clog2(BHT_DEPTH);

    typedef enum logic [2:0] {
        COND_NE   = 3'd0,
        COND_E    = 3'd1,
        COND_GT   = 3'd2,
        COND_LT   = 3'd3,
        COND_GE   = 3'd4,
        COND_LE   = 3'd5,
        COND_OV   = 3'd6,
        COND_TRUE = 3'd7
    } cond_e;

    logic [1:0]       bht [BHT_DEPTH];
    logic [IDX_W-1:0] id_idx;
    logic [IDX_W-1:0] rs_idx;
    logic [2:0]       eff_flags;
    logic             flag_z;
    logic             flag_n;
    logic             flag_v;
    logic             cond_true;
    logic             br_fire;
    logic             taken;
    logic             mispredict_d;
    logic [1:0]       rs_ctr;
    logic [1:0]       rs_ctr_next;
    logic             unused_pc;

    // Halfword-aligned PCs: bit 0 carries no information, upper bits alias.
    assign id_idx    = id_pc[IDX_W:1];
    assign rs_idx    = rs_pc[IDX_W:1];
    assign unused_pc = ^{id_pc[PC_W-1:IDX_W+1], id_pc[0], rs_pc[PC_W-1:IDX_W+1], rs_pc[0]};

    // Flags written this cycle are visible to the branch resolving in the same cycle.
    assign eff_flags = flag_we ? flag_in : flag_q;
    assign flag_z    = eff_flags[0];
    assign flag_n    = eff_flags[1];
    assign flag_v    = eff_flags[2];

    always_comb begin
        cond_true = 1'b0;
        case (cond_e'(rs_cond))
            COND_NE:   cond_true = ~flag_z;
            COND_E:    cond_true = flag_z;
            COND_GT:   cond_true = ~flag_z & ~flag_n;
            COND_LT:   cond_true = flag_n;
            COND_GE:   cond_true = flag_z | (~flag_z & ~flag_n);
            COND_LE:   cond_true = flag_z | flag_n;
            COND_OV:   cond_true = flag_v;
            COND_TRUE: cond_true = 1'b1;
            default:   cond_true = 1'b0;
        endcase
    end

    assign br_fire      = rs_valid & rs_b;
    assign taken        = br_fire & cond_true;
    assign mispredict_d = br_fire & (taken ^ rs_pred_taken);

    // Read-before-write: ID sees the counter as it was before this cycle's update.
    assign id_pred_taken = bht[id_idx][1];

    assign rs_ctr = bht[rs_idx];

    always_comb begin
        rs_ctr_next = rs_ctr;
        if (taken) begin
            if (rs_ctr != 2'b11) rs_ctr_next = rs_ctr + 2'd1;
        end else begin
            if (rs_ctr != 2'b00) rs_ctr_next = rs_ctr - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= 2'b01;
        end else if (br_fire) begin
            bht[rs_idx] <= rs_ctr_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flag_q     <= 3'b000;
            b_s        <= 1'b0;
            mispredict <= 1'b0;
            flush      <= 1'b0;
        end else begin
            if (flag_we) flag_q <= flag_in;
            b_s        <= taken;
            mispredict <= mispredict_d;
            flush      <= mispredict_d;
        end
    end

    // Statistics counters stick at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            br_count      <= '0;
            mispred_count <= '0;
        end else begin
            if (br_fire && (br_count != {CNT_W{1'b1}}))
                br_count <= br_count + CNT_W'(1);
            if (mispredict_d && (mispred_count != {CNT_W{1'b1}}))
                mispred_count <= mispred_count + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_branch_resolve_pred.sv
// tb/tb_branch_resolve_pred.sv - self-checking bench for branch_resolve_pred
module tb_branch_resolve_pred;
    localparam int PC_W  = 16;
    localparam int DEPTH = 16;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flag_we = 1'b0;
    logic [2:0]       flag_in = 3'b000;
    logic [2:0]       flag_q;
    logic [PC_W-1:0]  id_pc = '0;
    logic             id_pred_taken;
    logic             rs_valid = 1'b0;
    logic             rs_b = 1'b0;
    logic [2:0]       rs_cond = 3'd0;
    logic [PC_W-1:0]  rs_pc = '0;
    logic             rs_pred_taken = 1'b0;
    logic             b_s;
    logic             mispredict;
    logic             flush;
    logic [CNT_W-1:0] br_count;
    logic [CNT_W-1:0] mispred_count;

    branch_resolve_pred #(.PC_W(PC_W), .BHT_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .flag_we(flag_we), .flag_in(flag_in), .flag_q(flag_q),
        .id_pc(id_pc), .id_pred_taken(id_pred_taken), .rs_valid(rs_valid), .rs_b(rs_b),
        .rs_cond(rs_cond), .rs_pc(rs_pc), .rs_pred_taken(rs_pred_taken), .b_s(b_s),
        .mispredict(mispredict), .flush(flush), .br_count(br_count),
        .mispred_count(mispred_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    // Reference state
    int   bht_m [DEPTH];
    logic [2:0] flags_m;
    int   brc_m, mpc_m;
    logic exp_bs, exp_mp, exp_fl;
    bit   known = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit holds(input int c, input logic [2:0] f);
        bit z, n, v;
        z = f[0]; n = f[1]; v = f[2];
        case (c)
            0: return !z;
            1: return z;
            2: return !z && !n;
            3: return n;
            4: return z || !n;
            5: return z || n;
            6: return v;
            default: return 1;
        endcase
    endfunction

    function automatic int idx_of(input logic [PC_W-1:0] pc);
        return (int'(pc) / 2) % DEPTH;
    endfunction

    // One clock: check the comb prediction, advance the model, check registered outputs.
    task automatic cycle();
        bit t;
        logic [2:0] eff;
        int ri;
        #2;
        if (known) chk("id_pred", id_pred_taken, bht_m[idx_of(id_pc)] >= 2);
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) bht_m[i] = 1;
            flags_m = 3'b000; brc_m = 0; mpc_m = 0;
            exp_bs = 0; exp_mp = 0; exp_fl = 0;
            known = 1;
        end else begin
            eff = flag_we ? flag_in : flags_m;
            t = rs_valid && rs_b && holds(int'(rs_cond), eff);
            if (flag_we) flags_m = flag_in;
            exp_bs = t;
            exp_mp = rs_valid && rs_b && (t != rs_pred_taken);
            exp_fl = exp_mp;
            if (rs_valid && rs_b) begin
                ri = idx_of(rs_pc);
                bht_m[ri] = t ? ((bht_m[ri] < 3) ? bht_m[ri] + 1 : 3)
                              : ((bht_m[ri] > 0) ? bht_m[ri] - 1 : 0);
                if (brc_m < CMAX) brc_m++;
            end
            if (exp_mp && mpc_m < CMAX) mpc_m++;
        end
        @(posedge clk);
        #1;
        chk("flag_q", flag_q, flags_m);
        chk("b_s", b_s, exp_bs);
        chk("mispredict", mispredict, exp_mp);
        chk("flush", flush, exp_fl);
        chk("br_count", br_count, brc_m);
        chk("mispred_count", mispred_count, mpc_m);
    endtask

    task automatic idle();
        rst = 0; flag_we = 0; rs_valid = 0; rs_b = 0; rs_pred_taken = 0;
    endtask

    task automatic branch(input logic [2:0] c, input logic [PC_W-1:0] pc, input logic pred);
        rs_valid = 1; rs_b = 1; rs_cond = c; rs_pc = pc; rs_pred_taken = pred;
    endtask

    logic [7:0] t2_exp;

    initial begin
        // T1 reset
        rst = 1;
        cycle();
        idle();
        chk("t1_flag_q", flag_q, 3'b000);
        chk("t1_br_count", br_count, 0);
        for (int i = 0; i < DEPTH; i++) begin
            id_pc = PC_W'(i * 2);
            #1;
            chk("t1_id_pred", id_pred_taken, 1'b0);
        end

        // T2 conditions with Z=1
        flag_we = 1; flag_in = 3'b001;
        cycle();
        idle();
        t2_exp = 8'b1011_0010;
        for (int c = 0; c < 8; c++) begin
            branch(3'(c), PC_W'(16'h0040 + c * 2), 1'b0);
            cycle();
            chk("t2_b_s", b_s, t2_exp[c]);
        end
        idle();

        // T3 flag bypass
        flag_we = 1; flag_in = 3'b000;
        cycle();
        flag_we = 1; flag_in = 3'b100;
        branch(3'd6, 16'h0060, 1'b0);
        cycle();
        idle();
        chk("t3_b_s", b_s, 1'b1);
        chk("t3_flush", flush, 1'b1);
        chk("t3_flag_q", flag_q, 3'b100);
        cycle();
        chk("t3_flush_pulse", flush, 1'b0);

        // T4 saturation on idx 2 (flags 0 -> OV not taken)
        rst = 1; cycle(); idle();
        id_pc = 16'h0004;
        for (int k = 0; k < 3; k++) begin branch(3'd7, 16'h0004, 1'b0); cycle(); end
        idle(); #1;
        chk("t4_sat_hi", id_pred_taken, 1'b1);
        id_pc = 16'h0024; #1;
        chk("t4_alias", id_pred_taken, 1'b1);
        id_pc = 16'h0004;
        for (int k = 0; k < 4; k++) begin branch(3'd6, 16'h0004, 1'b1); cycle(); end
        idle(); #1;
        chk("t4_sat_lo", id_pred_taken, 1'b0);

        // T5 read/write collision
        rst = 1; cycle(); idle();
        id_pc = 16'h0008;
        branch(3'd7, 16'h0008, 1'b0);
        #1;
        chk("t5_old", id_pred_taken, 1'b0);
        cycle();
        idle(); #1;
        chk("t5_new", id_pred_taken, 1'b1);

        // T6 counter saturation
        rst = 1; cycle(); idle();
        for (int k = 0; k < 20; k++) begin branch(3'd7, PC_W'(k * 2), 1'b0); cycle(); end
        chk("t6_br_sat", br_count, 4'hf);
        chk("t6_mp_sat", mispred_count, 4'hf);
        branch(3'd7, 16'h0002, 1'b0); rs_b = 0;
        cycle();
        chk("t6_nb_b_s", b_s, 1'b0);
        chk("t6_nb_cnt", br_count, 4'hf);
        idle();

        // Mid-operation reset discards the result in flight
        branch(3'd7, 16'h000a, 1'b0); rst = 1;
        cycle();
        chk("rst_flush", flush, 1'b0);
        idle();

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            rst           = ($urandom_range(0, 59) == 0);
            flag_we       = $urandom_range(0, 2) == 0;
            flag_in       = 3'($urandom);
            id_pc         = PC_W'($urandom_range(0, 63));
            rs_valid      = $urandom_range(0, 3) != 0;
            rs_b          = $urandom_range(0, 5) != 0;
            rs_cond       = 3'($urandom);
            rs_pc         = ($urandom_range(0, 3) == 0) ? id_pc : PC_W'($urandom_range(0, 63));
            rs_pred_taken = 1'($urandom);
            cycle();
        end
        idle();
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
